fibo_seq_engine: RTL and testbench

//  Parametrised successor to the fixed 5-bit-index / 20-bit-result Fibonacci unit.

---
 rtl/fibo_pkg.sv | 17 +
 rtl/fibo_add_step.sv | 33 +++
 rtl/fibo_seq_engine.sv | 109 ++++++++++
 tb/tb_fibo_seq_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared state type and default widths for the Fibonacci sequence engine
// Contents:
//   fibo_state_t     FSM state encoding (IDLE, OP, DONE)
//   FIBO_IDX_W_DEF   default width of the requested index
//   FIBO_F_W_DEF     default width of seeds, datapath and result
package fibo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } fibo_state_t;

   localparam int FIBO_IDX_W_DEF = 5;
   localparam int FIBO_F_W_DEF   = 20;

endpackage

// File: rtl/fibo_add_step.sv
// rtl/fibo_add_step.sv - one combinational recurrence step: next term and its overflow flag
// Build option: FIBO_SAT_EN (defined: saturate the new term to all-ones once overflow is seen;
//               undefined: the new term wraps modulo 2**F_W).
// Ports:
//   t0, t1     in   F_W  the two most recent terms
//   v0, v1     in   1    overflow flags belonging to t0, t1
//   next_t1    out  F_W  new term t0+t1 (wrapped or saturated)
//   next_v1    out  1    overflow flag belonging to next_t1
module fibo_add_step #(
   parameter int F_W = 20
) (
   input  logic [F_W-1:0] t0,
   input  logic [F_W-1:0] t1,
   input  logic           v0,
   input  logic           v1,
   output logic [F_W-1:0] next_t1,
   output logic           next_v1
);

   logic [F_W:0] full_sum;

   assign full_sum = {1'b0, t0} + {1'b0, t1};

   // A term is out of range if its own add carried or either operand already was.
   assign next_v1 = v0 | v1 | full_sum[F_W];

`ifdef FIBO_SAT_EN
   assign next_t1 = next_v1 ? {F_W{1'b1}} : full_sum[F_W-1:0];
`else
   assign next_t1 = full_sum[F_W-1:0];
`endif

endmodule

// File: rtl/fibo_seq_engine.sv
// rtl/fibo_seq_engine.sv - start/ready Fibonacci-style term generator with overflow flag and abort
// Build option: FIBO_SAT_EN (saturating datapath, handled inside fibo_add_step).
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      synchronous active-high reset
//   start_i      in   1      request, accepted only while ready_o=1
//   abort_i      in   1      cancel an in-flight computation (OP only)
//   idx_i        in   IDX_W  requested index n, sampled at accept
//   seed0_i      in   F_W    f(0), sampled at accept
//   seed1_i      in   F_W    f(1), sampled at accept
//   ready_o      out  1      high in IDLE only
//   done_tick_o  out  1      one-cycle pulse when f_o/ovf_o carry a new result
//   f_o          out  F_W    result f(n), held until the next completion
//   ovf_o        out  1      f(n) exceeded 2**F_W-1, held with f_o
module fibo_seq_engine
   import fibo_pkg::*;
#(
   parameter int IDX_W = FIBO_IDX_W_DEF,
   parameter int F_W   = FIBO_F_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [F_W-1:0]   seed0_i,
   input  logic [F_W-1:0]   seed1_i,
   output logic             ready_o,
   output logic             done_tick_o,
   output logic [F_W-1:0]   f_o,
   output logic             ovf_o
);

   fibo_state_t      state;
   logic [IDX_W-1:0] n;
   logic [F_W-1:0]   t0;
   logic [F_W-1:0]   t1;
   logic             v0;
   logic             v1;
   logic [F_W-1:0]   next_t1;
   logic             next_v1;

   fibo_add_step #(.F_W(F_W)) u_add_step (
      .t0      (t0),
      .t1      (t1),
      .v0      (v0),
      .v1      (v1),
      .next_t1 (next_t1),
      .next_v1 (next_v1)
   );

   // The result is taken from t0, so an overflowed look-ahead t1 never flags f(n).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         ready_o     <= 1'b1;
         done_tick_o <= 1'b0;
         f_o         <= '0;
         ovf_o       <= 1'b0;
         n           <= '0;
         t0          <= '0;
         t1          <= '0;
         v0          <= 1'b0;
         v1          <= 1'b0;
      end else begin
         done_tick_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  n       <= idx_i;
                  t0      <= seed0_i;
                  t1      <= seed1_i;
                  v0      <= 1'b0;
                  v1      <= 1'b0;
                  ready_o <= 1'b0;
                  state   <= OP;
               end
            end
            OP: begin
               if (abort_i) begin
                  ready_o <= 1'b1;
                  state   <= IDLE;
               end else if (n == '0) begin
                  f_o   <= t0;
                  ovf_o <= v0;
                  state <= DONE;
               end else begin
                  t0 <= t1;
                  v0 <= v1;
                  t1 <= next_t1;
                  v1 <= next_v1;
                  n  <= n - IDX_W'(1);
               end
            end
            DONE: begin
               // Pulse and ready rise together as the FSM returns to IDLE.
               done_tick_o <= 1'b1;
               ready_o     <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               ready_o <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// tb/tb_fibo_seq_engine.sv - self-checking bench for fibo_seq_engine (vector table, corner sequences, random vs model)
module tb_fibo_seq_engine;

   localparam int IDX_W = 5;
   localparam int F_W   = 20;
   localparam longint MAXV = (64'd1 << F_W) - 1;

   typedef struct {
      int     idx;
      longint s0;
      longint s1;
      longint exp_f;
      longint exp_ovf;
   } vec_t;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             abort_i = 1'b0;
   logic [IDX_W-1:0] idx_i = '0;
   logic [F_W-1:0]   seed0_i = '0;
   logic [F_W-1:0]   seed1_i = '0;
   logic             ready_o;
   logic             done_tick_o;
   logic [F_W-1:0]   f_o;
   logic             ovf_o;

   int n_checks = 0;
   int n_errors = 0;

   fibo_seq_engine #(.IDX_W(IDX_W), .F_W(F_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .idx_i       (idx_i),
      .seed0_i     (seed0_i),
      .seed1_i     (seed1_i),
      .ready_o     (ready_o),
      .done_tick_o (done_tick_o),
      .f_o         (f_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: unbounded recurrence, then reduce to the output width.
   task automatic model(input int n, input longint s0, input longint s1,
                        output longint f, output longint ovf);
      longint a, b, c;
      a = s0;
      b = s1;
      for (int i = 0; i < n; i++) begin
         c = a + b;
         a = b;
         b = c;
      end
      ovf = (a > MAXV) ? 1 : 0;
`ifdef FIBO_SAT_EN
      f = (ovf != 0) ? MAXV : a;
`else
      f = a & MAXV;
`endif
   endtask

   // Called #1 after a rising edge; returns #1 after the edge following the pulse.
   task automatic run_op(input string name, input int n, input longint s0, input longint s1,
                         input logic with_abort, input longint exp_f, input longint exp_ovf);
      int lat;
      logic busy_ok;
      check({name, "_ready_pre"}, ready_o, 1);
      idx_i   = IDX_W'(n);
      seed0_i = F_W'(s0);
      seed1_i = F_W'(s1);
      start_i = 1'b1;
      abort_i = with_abort;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      idx_i   = IDX_W'($urandom);
      seed0_i = F_W'($urandom);
      seed1_i = F_W'($urandom);
      lat = 0;
      busy_ok = 1'b1;
      while (lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
         if (done_tick_o) break;
         if (ready_o) busy_ok = 1'b0;
      end
      check({name, "_latency"}, lat, n + 2);
      check({name, "_busy"}, busy_ok, 1);
      check({name, "_f"}, f_o, exp_f);
      check({name, "_ovf"}, ovf_o, exp_ovf);
      @(posedge clk_i); #1;
      check({name, "_pulse"}, done_tick_o, 0);
   endtask

   vec_t vecs[$];
   longint ef, eo;
   int dones;

   initial begin
      vecs.push_back('{0, 0, 1, 0, 0});
      vecs.push_back('{1, 0, 1, 1, 0});
      vecs.push_back('{7, 0, 1, 13, 0});
      vecs.push_back('{7, 2, 1, 29, 0});
      vecs.push_back('{30, 0, 1, 832040, 0});
`ifdef FIBO_SAT_EN
      vecs.push_back('{31, 0, 1, 1048575, 1});
`else
      vecs.push_back('{31, 0, 1, 297693, 1});
`endif
      vecs.push_back('{20, 0, 1, 6765, 0});
      vecs.push_back('{2, 3, 4, 7, 0});

      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check("rst_ready", ready_o, 1);
      check("rst_done", done_tick_o, 0);
      check("rst_f", f_o, 0);
      check("rst_ovf", ovf_o, 0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].s0, vecs[i].s1, 1'b0,
                vecs[i].exp_f, vecs[i].exp_ovf);

      // start while busy must be ignored
      idx_i = 5'd7; seed0_i = 20'd2; seed1_i = 20'd1; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (2) @(posedge clk_i); #1;
      idx_i = 5'd1; seed0_i = 20'd0; seed1_i = 20'd1; start_i = 1'b1;
      repeat (2) @(posedge clk_i); #1;
      start_i = 1'b0;
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk_i); #1;
         if (done_tick_o) begin
            dones++;
            check("busy_f", f_o, 29);
         end
      end
      check("busy_single_done", dones, 1);

      // abort in OP cycle 5: no result, previous result kept
      run_op("pre_abort", 7, 0, 1, 1'b0, 13, 0);
      idx_i = 5'd20; seed0_i = 20'd0; seed1_i = 20'd1; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk_i); #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      check("abort_ready", ready_o, 1);
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_i); #1;
         if (done_tick_o) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_keep_f", f_o, 13);
      check("abort_keep_ovf", ovf_o, 0);
      run_op("post_abort", 20, 0, 1, 1'b0, 6765, 0);

      // abort together with start in IDLE: start wins
      run_op("start_abort", 5, 2, 1, 1'b1, 11, 0);

      // reset mid-operation
      idx_i = 5'd25; seed0_i = 20'd0; seed1_i = 20'd1; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("midrst_ready", ready_o, 1);
      check("midrst_done", done_tick_o, 0);
      check("midrst_f", f_o, 0);
      check("midrst_ovf", ovf_o, 0);
      run_op("after_rst", 2, 3, 4, 1'b0, 7, 0);

      // random requests against the model
      for (int r = 0; r < 40; r++) begin
         int n;
         longint s0, s1;
         n  = $urandom_range(0, 31);
         s0 = longint'($urandom_range(0, 1048575));
         s1 = longint'($urandom_range(0, 1048575));
         if (r % 3 == 0) begin
            s0 = longint'($urandom_range(0, 15));
            s1 = longint'($urandom_range(0, 15));
         end
         model(n, s0, s1, ef, eo);
         run_op($sformatf("rnd%0d", r), n, s0, s1, 1'b0, ef, eo);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
